// File: rtl/score_tracker_if.sv
// Bundle of game-event inputs and score/status outputs shared by the hit-judgement
// logic (master) and score_tracker (slave).
interface score_tracker_if #(
    parameter int SCORE_W   = 14,
    parameter int COMBO_W   = 14,
    parameter int MAX_LIVES = 3
);
    localparam int LIFE_W = $clog2(MAX_LIVES + 1);

    // No valid/ready pair: event lines are levels whose rising edges count as one event each;
    // clear/enable are synchronous to clk and the status outputs are always valid.
    logic               clear;
    logic               enable;
    logic               hit_perfect;
    logic               hit_good;
    logic               miss;
    logic [SCORE_W-1:0] score;
    logic [COMBO_W-1:0] combo;
    logic [COMBO_W-1:0] max_combo;
    logic [3:0]         multiplier;
    logic [COMBO_W-1:0] misses;
    logic [LIFE_W-1:0]  lives;
    logic               game_over;
    logic [SCORE_W-1:0] high_score;
    logic               new_high;

    modport master (
        output clear, enable, hit_perfect, hit_good, miss,
        input  score, combo, max_combo, multiplier, misses, lives, game_over, high_score, new_high
    );

    modport slave (
        input  clear, enable, hit_perfect, hit_good, miss,
        output score, combo, max_combo, multiplier, misses, lives, game_over, high_score, new_high
    );
endinterface

// File: rtl/score_tracker.sv
// Rhythm-game scoring engine: synchronises hit/miss levels into one-cycle events and keeps
// score, combo multiplier, lives, max combo and a cross-game high score, all saturating.
module score_tracker #(
    parameter int SCORE_W     = 14,
    parameter int COMBO_W     = 14,
    parameter int MAX_LIVES   = 3,
    parameter int PERFECT_PTS = 3,
    parameter int GOOD_PTS    = 1,
    parameter int T2          = 4,
    parameter int T4          = 10,
    parameter int T8          = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    score_tracker_if.slave bus
);
    localparam int LIFE_W = $clog2(MAX_LIVES + 1);
    // Wide enough for score plus the largest base*8 product without overflow.
    localparam int PW     = SCORE_W + 16;

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [COMBO_W-1:0] COMBO_MAX = '1;
    localparam logic [LIFE_W-1:0]  LIVES_INI = LIFE_W'(MAX_LIVES);

    // Bit order in the event vectors: [2]=miss, [1]=hit_perfect, [0]=hit_good.
    logic [2:0] raw_in;
    logic [2:0] sync1_q, sync2_q, prev_q;
    logic [2:0] pulse;

    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] high_score_q, high_score_d;
    logic [SCORE_W-1:0] hs_base_q, hs_base_d;
    logic [COMBO_W-1:0] combo_q, combo_d;
    logic [COMBO_W-1:0] max_combo_q, max_combo_d;
    logic [COMBO_W-1:0] misses_q, misses_d;
    logic [3:0]         mult_q, mult_d;
    logic [LIFE_W-1:0]  lives_q, lives_d;
    logic               game_over_q, game_over_d;
    logic               new_high_q, new_high_d;

    logic               accept;
    logic               is_miss, is_perf, is_good;
    logic [PW-1:0]      base;
    logic [PW-1:0]      sum;
    logic [COMBO_W-1:0] combo_inc;

    function automatic logic [3:0] mult_of(input logic [COMBO_W-1:0] c);
        logic [31:0] cw;
        cw = 32'(c);
        if (cw >= 32'(T8))      return 4'd8;
        else if (cw >= 32'(T4)) return 4'd4;
        else if (cw >= 32'(T2)) return 4'd2;
        else                    return 4'd1;
    endfunction

    assign raw_in = {bus.miss, bus.hit_perfect, bus.hit_good};
    assign pulse  = sync2_q & ~prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    always_comb begin
        accept  = bus.enable && !game_over_q && !bus.clear;
        is_miss = accept && pulse[2];
        is_perf = accept && pulse[1] && !pulse[2];
        is_good = accept && pulse[0] && !pulse[2] && !pulse[1];
    end

    always_comb begin
        base      = is_perf ? PW'(PERFECT_PTS) : PW'(GOOD_PTS);
        sum       = PW'(score_q) + base * PW'(mult_of(combo_q));
        combo_inc = (combo_q == COMBO_MAX) ? combo_q : combo_q + 1'b1;
    end

    always_comb begin
        score_d      = score_q;
        high_score_d = high_score_q;
        hs_base_d    = hs_base_q;
        combo_d      = combo_q;
        max_combo_d  = max_combo_q;
        misses_d     = misses_q;
        mult_d       = mult_q;
        lives_d      = lives_q;
        game_over_d  = game_over_q;
        new_high_d   = new_high_q;

        if (bus.clear) begin
            score_d     = '0;
            combo_d     = '0;
            max_combo_d = '0;
            misses_d    = '0;
            mult_d      = 4'd1;
            lives_d     = LIVES_INI;
            game_over_d = 1'b0;
            new_high_d  = 1'b0;
            // The new game must beat whatever the record is right now.
            hs_base_d   = high_score_q;
        end else begin
            if (is_miss) begin
                combo_d  = '0;
                mult_d   = 4'd1;
                misses_d = (misses_q == COMBO_MAX) ? misses_q : misses_q + 1'b1;
                if (lives_q != '0) begin
                    lives_d = lives_q - 1'b1;
                end
                if (lives_q == LIFE_W'(1)) begin
                    game_over_d = 1'b1;
                end
            end else if (is_perf || is_good) begin
                score_d     = (sum > PW'(SCORE_MAX)) ? SCORE_MAX : sum[SCORE_W-1:0];
                combo_d     = combo_inc;
                max_combo_d = (combo_inc > max_combo_q) ? combo_inc : max_combo_q;
                mult_d      = mult_of(combo_inc);
            end

            if (score_d > high_score_q) begin
                high_score_d = score_d;
            end
            if (score_d > hs_base_q) begin
                new_high_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_q      <= '0;
            high_score_q <= '0;
            hs_base_q    <= '0;
            combo_q      <= '0;
            max_combo_q  <= '0;
            misses_q     <= '0;
            mult_q       <= 4'd1;
            lives_q      <= LIVES_INI;
            game_over_q  <= 1'b0;
            new_high_q   <= 1'b0;
        end else begin
            score_q      <= score_d;
            high_score_q <= high_score_d;
            hs_base_q    <= hs_base_d;
            combo_q      <= combo_d;
            max_combo_q  <= max_combo_d;
            misses_q     <= misses_d;
            mult_q       <= mult_d;
            lives_q      <= lives_d;
            game_over_q  <= game_over_d;
            new_high_q   <= new_high_d;
        end
    end

    assign bus.score      = score_q;
    assign bus.combo      = combo_q;
    assign bus.max_combo  = max_combo_q;
    assign bus.multiplier = mult_q;
    assign bus.misses     = misses_q;
    assign bus.lives      = lives_q;
    assign bus.game_over  = game_over_q;
    assign bus.high_score = high_score_q;
    assign bus.new_high   = new_high_q;
endmodule

// File: tb/tb_score_tracker.sv
// Bench for score_tracker: a default-width instance and a 6-bit-score instance share one
// stimulus stream and are compared against a rule-level game model.
`timescale 1ns/1ps
module tb_score_tracker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear_r = 1'b0, en_r = 1'b1, perf_r = 1'b0, good_r = 1'b0, miss_r = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  score_tracker_if #(.SCORE_W(14), .COMBO_W(14), .MAX_LIVES(3)) b0 ();
  score_tracker_if #(.SCORE_W(6), .COMBO_W(14), .MAX_LIVES(3)) b1 ();

  assign b0.clear = clear_r;  assign b1.clear = clear_r;
  assign b0.enable = en_r;    assign b1.enable = en_r;
  assign b0.hit_perfect = perf_r; assign b1.hit_perfect = perf_r;
  assign b0.hit_good = good_r;    assign b1.hit_good = good_r;
  assign b0.miss = miss_r;        assign b1.miss = miss_r;

  score_tracker #(.SCORE_W(14)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  score_tracker #(.SCORE_W(6))  dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  // ---------------- reference model ----------------
  int m_score[2], m_hs[2], m_hsb[2];
  bit m_nh[2];
  int smax[2] = '{16383, 63};
  int m_combo, m_maxc, m_misses, m_lives;
  bit m_go;

  function automatic int f_mult(input int c);
    if (c >= 15) return 8;
    if (c >= 10) return 4;
    if (c >= 4) return 2;
    return 1;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_score[i] = 0; m_hs[i] = 0; m_hsb[i] = 0; m_nh[i] = 0;
    end
    m_combo = 0; m_maxc = 0; m_misses = 0; m_lives = 3; m_go = 0;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 2; i++) begin
      m_score[i] = 0; m_hsb[i] = m_hs[i]; m_nh[i] = 0;
    end
    m_combo = 0; m_maxc = 0; m_misses = 0; m_lives = 3; m_go = 0;
  endfunction

  // m: [2]=miss [1]=perfect [0]=good, all rising in the same cycle
  function automatic void model_event(input logic [2:0] m);
    int base;
    if (!en_r || m_go || m == 3'b000) return;
    if (m[2]) begin
      m_combo = 0;
      if (m_misses < 16383) m_misses++;
      if (m_lives > 0) m_lives--;
      if (m_lives == 0) m_go = 1;
    end else begin
      base = m[1] ? 3 : 1;
      for (int i = 0; i < 2; i++) begin
        m_score[i] = m_score[i] + base * f_mult(m_combo);
        if (m_score[i] > smax[i]) m_score[i] = smax[i];
        if (m_score[i] > m_hs[i]) m_hs[i] = m_score[i];
        if (m_score[i] > m_hsb[i]) m_nh[i] = 1;
      end
      if (m_combo < 16383) m_combo++;
      if (m_combo > m_maxc) m_maxc = m_combo;
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic fire(input logic [2:0] m, input int hold);
    @(negedge clk);
    {miss_r, perf_r, good_r} = m;
    model_event(m);
    repeat (hold) @(negedge clk);
    {miss_r, perf_r, good_r} = 3'b000;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear_r = 1'b1;
    model_clear();
    @(negedge clk);
    clear_r = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_checks++; if (b0.score !== 14'd0) begin n_fail++; $display("FAIL reset score got=%0d exp=0", b0.score); end
    n_checks++; if (b0.high_score !== 14'd0) begin n_fail++; $display("FAIL reset high_score got=%0d exp=0", b0.high_score); end
    n_checks++; if (b0.combo !== 14'd0 || b0.max_combo !== 14'd0 || b0.misses !== 14'd0) begin n_fail++; $display("FAIL reset counters got=%0d/%0d/%0d exp=0/0/0", b0.combo, b0.max_combo, b0.misses); end
    n_checks++; if (b0.multiplier !== 4'd1) begin n_fail++; $display("FAIL reset multiplier got=%0d exp=1", b0.multiplier); end
    n_checks++; if (b0.lives !== 2'd3) begin n_fail++; $display("FAIL reset lives got=%0d exp=3", b0.lives); end
    n_checks++; if (b0.game_over !== 1'b0 || b0.new_high !== 1'b0) begin n_fail++; $display("FAIL reset flags got=%b%b exp=00", b0.game_over, b0.new_high); end
  endtask

  task automatic test_good_hits();
    int exp_tbl[5] = '{1, 2, 3, 4, 6};
    for (int k = 0; k < 5; k++) begin
      fire(3'b001, $urandom_range(1, 3));
      n_checks++; if (b0.score !== 14'(m_score[0]) || m_score[0] != exp_tbl[k]) begin n_fail++; $display("FAIL good_hit%0d score got=%0d exp=%0d", k, b0.score, exp_tbl[k]); end
      n_checks++; if (b0.multiplier !== 4'(f_mult(m_combo))) begin n_fail++; $display("FAIL good_hit%0d multiplier got=%0d exp=%0d", k, b0.multiplier, f_mult(m_combo)); end
    end
    n_checks++; if (b0.combo !== 14'd5 || b0.max_combo !== 14'd5) begin n_fail++; $display("FAIL good_hits combo/max got=%0d/%0d exp=5/5", b0.combo, b0.max_combo); end
  endtask

  task automatic test_perfect_run();
    do_clear();
    for (int k = 0; k < 16; k++) begin
      fire(3'b010, $urandom_range(1, 2));
      n_checks++; if (b1.score !== 6'(m_score[1])) begin n_fail++; $display("FAIL sat_score hit%0d got=%0d exp=%0d", k, b1.score, m_score[1]); end
    end
    n_checks++; if (b0.score !== 14'd132 || m_score[0] != 132) begin n_fail++; $display("FAIL perfect_run score got=%0d exp=132", b0.score); end
    n_checks++; if (b0.combo !== 14'd16 || b0.multiplier !== 4'd8) begin n_fail++; $display("FAIL perfect_run combo/mult got=%0d/%0d exp=16/8", b0.combo, b0.multiplier); end
    n_checks++; if (b0.high_score !== 14'd132 || b0.new_high !== 1'b1) begin n_fail++; $display("FAIL perfect_run high got=%0d/%b exp=132/1", b0.high_score, b0.new_high); end
    n_checks++; if (b1.score !== 6'd63 || b1.high_score !== 6'd63) begin n_fail++; $display("FAIL sat_final score/high got=%0d/%0d exp=63/63", b1.score, b1.high_score); end
  endtask

  task automatic test_priority();
    do_clear();
    repeat (3) fire(3'b010, 1);
    fire(3'b110, 2);
    n_checks++; if (b0.score !== 14'd9 || m_score[0] != 9) begin n_fail++; $display("FAIL priority score got=%0d exp=9", b0.score); end
    n_checks++; if (b0.combo !== 14'd0 || b0.multiplier !== 4'd1) begin n_fail++; $display("FAIL priority combo/mult got=%0d/%0d exp=0/1", b0.combo, b0.multiplier); end
    n_checks++; if (b0.lives !== 2'd2 || b0.misses !== 14'd1) begin n_fail++; $display("FAIL priority lives/misses got=%0d/%0d exp=2/1", b0.lives, b0.misses); end
    n_checks++; if (b0.max_combo !== 14'd3) begin n_fail++; $display("FAIL priority max_combo got=%0d exp=3", b0.max_combo); end
  endtask

  task automatic test_game_over();
    int hs_keep;
    fire(3'b100, 1);
    n_checks++; if (b0.game_over !== 1'b0 || b0.lives !== 2'd1) begin n_fail++; $display("FAIL gameover_pre go/lives got=%b/%0d exp=0/1", b0.game_over, b0.lives); end
    fire(3'b100, 1);
    n_checks++; if (b0.game_over !== 1'b1 || b0.lives !== 2'd0) begin n_fail++; $display("FAIL gameover go/lives got=%b/%0d exp=1/0", b0.game_over, b0.lives); end
    fire(3'b010, 1);
    n_checks++; if (b0.score !== 14'(m_score[0]) || b0.combo !== 14'd0) begin n_fail++; $display("FAIL gameover_ignore score/combo got=%0d/%0d exp=%0d/0", b0.score, b0.combo, m_score[0]); end
    hs_keep = m_hs[0];
    do_clear();
    n_checks++; if (b0.score !== 14'd0 || b0.lives !== 2'd3 || b0.game_over !== 1'b0 || b0.new_high !== 1'b0) begin n_fail++; $display("FAIL clear score/lives/go/nh got=%0d/%0d/%b/%b exp=0/3/0/0", b0.score, b0.lives, b0.game_over, b0.new_high); end
    n_checks++; if (b0.high_score !== 14'(hs_keep) || hs_keep != 132) begin n_fail++; $display("FAIL clear high_score got=%0d exp=132", b0.high_score); end
    n_checks++; if (b0.misses !== 14'd0 || b0.max_combo !== 14'd0 || b0.multiplier !== 4'd1) begin n_fail++; $display("FAIL clear misses/max/mult got=%0d/%0d/%0d exp=0/0/1", b0.misses, b0.max_combo, b0.multiplier); end
  endtask

  task automatic test_hold();
    fire(3'b001, 20);
    n_checks++; if (b0.score !== 14'd1 || b0.combo !== 14'd1) begin n_fail++; $display("FAIL hold score/combo got=%0d/%0d exp=1/1", b0.score, b0.combo); end
  endtask

  task automatic test_enable();
    en_r = 1'b0;
    fire(3'b010, 1);
    fire(3'b100, 1);
    fire(3'b001, 3);
    n_checks++; if (b0.score !== 14'(m_score[0]) || b0.combo !== 14'(m_combo) || b0.lives !== 2'(m_lives)) begin n_fail++; $display("FAIL enable_off score/combo/lives got=%0d/%0d/%0d exp=%0d/%0d/%0d", b0.score, b0.combo, b0.lives, m_score[0], m_combo, m_lives); end
    en_r = 1'b1;
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 9) == 0) do_clear();
      en_r = ($urandom_range(0, 4) != 0);
      fire(3'($urandom_range(1, 7)), $urandom_range(1, 3));
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if ((i == 0 && (b0.score !== 14'(m_score[0]) || b0.high_score !== 14'(m_hs[0]) || b0.new_high !== m_nh[0])) ||
            (i == 1 && (b1.score !== 6'(m_score[1]) || b1.high_score !== 6'(m_hs[1]) || b1.new_high !== m_nh[1]))) begin
          n_fail++;
          $display("FAIL rand%0d inst%0d score/high/nh got=%0d/%0d/%b exp=%0d/%0d/%b", k, i,
                   (i == 0) ? int'(b0.score) : int'(b1.score), (i == 0) ? int'(b0.high_score) : int'(b1.high_score),
                   (i == 0) ? b0.new_high : b1.new_high, m_score[i], m_hs[i], m_nh[i]);
        end
      end
      n_checks++;
      if (b0.combo !== 14'(m_combo) || b0.max_combo !== 14'(m_maxc) || b0.misses !== 14'(m_misses) ||
          b0.lives !== 2'(m_lives) || b0.game_over !== m_go || b0.multiplier !== 4'(f_mult(m_combo))) begin
        n_fail++;
        $display("FAIL rand%0d state combo/max/miss/lives/go/mult got=%0d/%0d/%0d/%0d/%b/%0d exp=%0d/%0d/%0d/%0d/%b/%0d", k,
                 b0.combo, b0.max_combo, b0.misses, b0.lives, b0.game_over, b0.multiplier,
                 m_combo, m_maxc, m_misses, m_lives, m_go, f_mult(m_combo));
      end
    end
    en_r = 1'b1;
  endtask

  task automatic test_reset_mid();
    do_clear();
    repeat (6) fire(3'b010, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    good_r = 1'b1;
    model_reset();
    #1;
    n_checks++; if (b0.score !== 14'd0 || b0.high_score !== 14'd0 || b1.high_score !== 6'd0) begin n_fail++; $display("FAIL reset_mid score/high/high6 got=%0d/%0d/%0d exp=0/0/0", b0.score, b0.high_score, b1.high_score); end
    n_checks++; if (b0.lives !== 2'd3 || b0.multiplier !== 4'd1 || b0.combo !== 14'd0 || b0.max_combo !== 14'd0 || b0.new_high !== 1'b0) begin n_fail++; $display("FAIL reset_mid lives/mult/combo/max/nh got=%0d/%0d/%0d/%0d/%b exp=3/1/0/0/0", b0.lives, b0.multiplier, b0.combo, b0.max_combo, b0.new_high); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_event(3'b001);
    repeat (5) @(negedge clk);
    good_r = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (b0.score !== 14'(m_score[0]) || m_score[0] != 1 || b0.combo !== 14'd1) begin n_fail++; $display("FAIL held_through_reset score/combo got=%0d/%0d exp=1/1", b0.score, b0.combo); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_good_hits();
    test_perfect_run();
    test_priority();
    test_game_over();
    test_hold();
    test_enable();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/score_tracker.md
# score_tracker

Parametrised next-generation scoring engine for the rhythm game. It sits between the arrow hit-judgement logic and the display/seven-segment drivers. It counts graded hits (perfect/good) and misses from asynchronous level inputs, and applies combo-based multipliers with configurable thresholds. It tracks lives with a sticky game-over, and keeps per-game maximum combo and a cross-game high score with saturating arithmetic.

## Interface
- SCORE_W, 14, score/high-score width
- COMBO_W, 14, combo/max-combo/miss-count width
- MAX_LIVES, 3, lives per game (>=1); LIFE_W = $clog2(MAX_LIVES+1)
- PERFECT_PTS, 3, base points for a perfect hit
- GOOD_PTS, 1, base points for a good hit
- T2, 4 / T4, 10 / T8, 15, combo thresholds for x2/x4/x8 (T2<T4<T8 required)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous new-game clear, synchronous to clk
- enable  in  1  game running; events ignored when low
- hit_perfect  in  1  async level, event on rising edge
- hit_good  in  1  async level, event on rising edge
- miss  in  1  async level, event on rising edge
- score  out  SCORE_W  current game score
- combo  out  COMBO_W  current consecutive-hit count
- max_combo  out  COMBO_W  largest combo this game
- multiplier  out  4  current multiplier (1,2,4,8)
- misses  out  COMBO_W  misses this game
- lives  out  LIFE_W  lives remaining
- game_over  out  1  sticky, lives exhausted
- high_score  out  SCORE_W  best score since rst_n
- new_high  out  1  sticky, this game beat prior high_score

## Operation
- Each event input uses a 2-flop synchroniser, then a previous-value flop. Event pulse = sync & ~prev, active for one cycle per rising edge. A held level yields exactly one event.
- Event priority in one cycle: miss > hit_perfect > hit_good. Losers are dropped.
- Events are accepted only when enable=1, game_over=0 and clear=0.
- Multiplier function f(c): 8 if c>=T8, else 4 if c>=T4, else 2 if c>=T2, else 1.
- On an accepted hit:
  - score += base*f(combo_old), saturating at 2^SCORE_W-1.
  - combo += 1, saturating.
  - max_combo = max(max_combo, combo_new).
  - multiplier = f(combo_new).
- On an accepted miss:
  - combo=0, multiplier=1.
  - misses += 1, saturating.
  - lives -= 1 when lives>0.
  - game_over=1 on the same edge that lives becomes 0.
- High score: on the edge where score_next > high_score, high_score<=score_next on that same edge. new_high<=1 if score_next > the high_score held at the last clear or reset.
- clear takes priority over events:
  - score, combo, max_combo and misses go to 0.
  - multiplier=1, lives=MAX_LIVES.
  - game_over=0, new_high=0.
  - high_score is retained.
  - Synchroniser flops keep running.
- Reset values (rst_n=0, immediate): all counters, score and high_score = 0; multiplier=1; lives=MAX_LIVES; game_over=0; new_high=0; synchroniser and prev flops = 0.
- All outputs are driven directly from registers, with no combinational path from inputs.

## Timing
- An input rising before edge 1 is captured at edge 1 and reaches the sync output at edge 2. Its pulse is valid between edges 2 and 3, and outputs update at edge 3. Latency is 3 edges.
- Inputs must be low for at least 2 cycles between events to register as separate events. Shorter gaps may merge into one.
- clear is sampled at each edge; its effect is visible the cycle after the edge.
- rst_n assertion acts immediately, mid-game included. Deassertion is assumed synchronised externally. A level held high through reset produces one event after release.
- Saturation boundaries: score stops at max with no wrap. combo and misses stop at 2^COMBO_W-1, and multiplier stays 8.

## Test plan
- Reset, enable=1, 5 separate good hits: score 1,2,3,4,6; combo=5; multiplier=2 after hit 4; max_combo=5.
- 16 perfect hits: score=132 (4x3 + 6x6 + 5x12 + 1x24), combo=16, multiplier=8; high_score=132, new_high=1.
- miss and hit_perfect rising together after 3 hits: miss wins. combo=0, multiplier=1, lives=2, misses=1, score unchanged.
- 3 misses: game_over=1, lives=0. A later perfect hit is ignored. Then pulse clear: score=0, lives=3, game_over=0, new_high=0, high_score retained.
- SCORE_W=6, repeated perfect hits: score saturates at 63 with no wrap. Holding hit_good high for 20 cycles adds exactly one event. enable=0 events are ignored.
- Assert rst_n=0 mid-game between edges: all outputs reach reset values immediately, including high_score=0 and lives=3.
